mem_stage_requester: RTL
========================

# mem_stage_requester

Memory-stage initiator of the ARM pipeline. Takes the load/store request latched in the EXE/MEM register and translates the byte address into a word index. It then issues the access to a word-addressed data memory over a valid/ready request channel plus a response channel. While the access is outstanding it holds `freeze_out` to stall the pipeline, and it presents load data on `result_out` in the cycle the pipeline is released.

## Interface
- `DATA_OFFSET`, default 1024: byte base of data space; subtracted from the ALU result.
- `WORD_COUNT`, default 64: words in data memory; the legal range is [DATA_OFFSET, DATA_OFFSET+4*WORD_COUNT).
- `ADDR_W`, default 6: word-index width; must equal clog2(WORD_COUNT).
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_res_in` in 32: byte address from the EXE/MEM register.
- `val_rm_in` in 32: store data.
- `mem_read_enable_in` in 1: load request.
- `mem_write_enable_in` in 1: store request.
- `freeze_out` out 1: stall for the pipeline (hold PC and all pipeline registers).
- `result_out` out 32: load data; 0 unless a load completes this cycle.
- `addr_err_out` out 1: one-cycle pulse for an out-of-range access, or for read and write asserted together.
- `mem_req_valid_out` out 1: request valid.
- `mem_req_we_out` out 1: 1 = write, 0 = read.
- `mem_req_addr_out` out ADDR_W: word index.
- `mem_req_wdata_out` out 32: write data.
- `mem_req_ready_in` in 1: responder accepts the request.
- `mem_rsp_valid_in` in 1: read data valid.
- `mem_rsp_rdata_in` in 32: read data.

## Operation
- Word index = (alu_res_in − DATA_OFFSET) >> 2. Bits [1:0] are ignored; no misalignment fault.
- The address is in range iff alu_res_in ≥ DATA_OFFSET and the index is < WORD_COUNT. Width rules:
  - Subtraction is 32-bit unsigned.
  - Borrow means out of range.
  - The index is truncated to ADDR_W only after the range check.
- An access is present when either enable is set. If both are set, the store is performed and `addr_err_out` pulses.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE, no access: stay in IDLE; freeze=0, result=0.
  - IDLE, out-of-range access: no request is issued; `addr_err_out`=1 for this cycle; freeze=0; result=0; stay in IDLE.
  - IDLE, in-range access: freeze=1 combinationally in the same cycle. Latch index, wdata and we, then go to REQ.
  - REQ: valid=1 with payload held stable until the handshake. On ready, a write goes to DONE and a read goes to WAIT_RSP. While ready is low, stay in REQ and keep valid high.
  - WAIT_RSP: freeze=1. On rsp_valid, latch rdata and go to DONE.
  - DONE: freeze=0, so the pipeline advances this cycle. `result_out` = latched rdata for a read, 0 for a write. Next state is IDLE.
- `freeze_out` = (IDLE & in-range access) | REQ | WAIT_RSP.
- `mem_rsp_valid_in` is ignored in every state except WAIT_RSP.
- One outstanding access at most. There is no timeout.

## Timing
- Reset values:
  - State: IDLE.
  - `freeze_out`, `mem_req_valid_out`, `mem_req_we_out`, `addr_err_out`: 0.
  - `result_out`, `mem_req_addr_out`, `mem_req_wdata_out`, and the rdata latch: 0.
- Reset mid-access: the next cycle is IDLE with valid=0. A late response is dropped.
- Minimum cycles with freeze high:
  - Read: 3 (IDLE, REQ accepted at once, rsp the next cycle), then 1 DONE cycle.
  - Write: 2 (IDLE, REQ accepted at once), then DONE.
- Back-to-back accesses: DONE → IDLE, and the next instruction is sampled in IDLE. There is one unfrozen cycle (DONE) between consecutive accesses.
- Request payload outputs are registered. `freeze_out` and `addr_err_out` are combinational from state and inputs.

## Structure
- Shared package `kolum_mem_pkg` holds:
  - the state enum (IDLE, REQ, WAIT_RSP, DONE);
  - the defaults DATA_OFFSET = 1024 and WORD_COUNT = 64, shared with the data memory.
- One sub-module, `mem_addr_xlate`: combinational offset subtraction, range check and word-index truncation. It is reused by the data memory for consistency.
- The top level contains the FSM, payload registers and rdata latch.

## Test plan
- Read at 1032, ready=1, rsp next cycle with rdata=0xDEADBEEF:
  - req addr=2, we=0;
  - freeze high for 3 cycles;
  - DONE cycle: result=0xDEADBEEF, freeze=0.
- Write 0x12345678 at 1276, ready held low 4 cycles: valid stays high with addr=63 and wdata stable throughout; after accept, one DONE cycle; result=0.
- Read at 1020 (below base) and at 1280 (index 64): no request; `addr_err_out` pulses for one cycle; freeze never asserts.
- Read and write both set at 1024, val_rm=5: write issued to index 0 with wdata=5; `addr_err_out` pulses.
- rst asserted in WAIT_RSP, then rsp_valid the following cycle: the FSM stays in IDLE; result=0; freeze=0.
- Back-to-back reads at 1024 then 1028: the two requests are separated by exactly one DONE cycle; index 0 then 1.

Source files
------------

// File: rtl/kolum_mem_pkg.sv
// Shared definitions for the memory-stage requester and the word-addressed data memory.
// Holds the requester FSM state type and the data-space placement defaults.
package kolum_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StDone
    } mem_state_e;

    localparam int unsigned DefaultDataOffset = 1024;
    localparam int unsigned DefaultWordCount  = 64;

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte-address to word-index translation with range check.
// Shared with the data memory so both sides agree on what is in range.
module mem_addr_xlate
    import kolum_mem_pkg::*;
#(
    parameter int unsigned DATA_OFFSET = DefaultDataOffset,
    parameter int unsigned WORD_COUNT  = DefaultWordCount,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic [31:0]       byte_addr,
    output logic              in_range,
    output logic [ADDR_W-1:0] word_idx
);

    logic [32:0] diff;

    // The extra top bit of the 33-bit difference is the borrow: address below the data base.
    assign diff     = {1'b0, byte_addr} - {1'b0, DATA_OFFSET};
    assign in_range = !diff[32] && (diff[31:0] < 32'(WORD_COUNT * 4));
    assign word_idx = diff[ADDR_W+1:2];

endmodule

// File: rtl/mem_stage_requester.sv
// Memory-stage initiator: turns the EXE/MEM load/store into a valid/ready request to the
// word-addressed data memory and freezes the pipeline until the access completes.
module mem_stage_requester
    import kolum_mem_pkg::*;
#(
    parameter int unsigned DATA_OFFSET = DefaultDataOffset,
    parameter int unsigned WORD_COUNT  = DefaultWordCount,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_res_in,
    input  logic [31:0]       val_rm_in,
    input  logic              mem_read_enable_in,
    input  logic              mem_write_enable_in,
    output logic              freeze_out,
    output logic [31:0]       result_out,
    output logic              addr_err_out,
    output logic              mem_req_valid_out,
    output logic              mem_req_we_out,
    output logic [ADDR_W-1:0] mem_req_addr_out,
    output logic [31:0]       mem_req_wdata_out,
    input  logic              mem_req_ready_in,
    input  logic              mem_rsp_valid_in,
    input  logic [31:0]       mem_rsp_rdata_in
);

    mem_state_e        state_q, state_d;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    logic              access, both_set, start;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    mem_addr_xlate #(
        .DATA_OFFSET(DATA_OFFSET),
        .WORD_COUNT (WORD_COUNT),
        .ADDR_W     (ADDR_W)
    ) u_xlate (
        .byte_addr(alu_res_in),
        .in_range (in_range),
        .word_idx (word_idx)
    );

    assign access   = mem_read_enable_in | mem_write_enable_in;
    assign both_set = mem_read_enable_in & mem_write_enable_in;
    assign start    = (state_q == StIdle) && access && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StReq;
            StReq:     if (mem_req_ready_in) state_d = we_q ? StDone : StWaitRsp;
            StWaitRsp: if (mem_rsp_valid_in) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Payload is captured once on entry so it stays stable through any ready stall;
    // a simultaneous read+write is performed as the store.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (start) begin
            we_d    = mem_write_enable_in;
            addr_d  = word_idx;
            wdata_d = val_rm_in;
        end
        if (state_q == StWaitRsp && mem_rsp_valid_in) begin
            rdata_d = mem_rsp_rdata_in;
        end
    end

    always_comb begin
        freeze_out        = start || state_q == StReq || state_q == StWaitRsp;
        addr_err_out      = (state_q == StIdle) && access && (!in_range || both_set);
        mem_req_valid_out = (state_q == StReq);
        mem_req_we_out    = we_q;
        mem_req_addr_out  = addr_q;
        mem_req_wdata_out = wdata_q;
        result_out        = (state_q == StDone && !we_q) ? rdata_q : 32'h0;
    end

endmodule
